seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 61 ++++++
 rtl/seg_glyph_rom.sv | 11 +
 rtl/seg_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, glyph constants and the 5-bit code to 7-segment lookup
// for the multiplexed seven-segment display driver.
package seg_pkg;

    localparam int unsigned CODE_W  = 5;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_W   = 8;

    localparam logic [CODE_W-1:0] GLYPH_A     = 5'd10;
    localparam logic [CODE_W-1:0] GLYPH_B     = 5'd11;
    localparam logic [CODE_W-1:0] GLYPH_C     = 5'd12;
    localparam logic [CODE_W-1:0] GLYPH_D     = 5'd13;
    localparam logic [CODE_W-1:0] GLYPH_E     = 5'd14;
    localparam logic [CODE_W-1:0] GLYPH_F     = 5'd15;
    localparam logic [CODE_W-1:0] GLYPH_P     = 5'd16;
    localparam logic [CODE_W-1:0] GLYPH_DASH  = 5'd17;
    localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'd31;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        GUARD_S = 1'b0,
        DRIVE_S = 1'b1
    } scan_state_e;

    // One frame-buffer entry per digit.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              dp;
        logic              blank;
    } digit_t;

    // Active-low gfedcba pattern; unassigned codes render dark.
    function automatic logic [GLYPH_W-1:0] glyph_lookup(input logic [CODE_W-1:0] code);
        logic [GLYPH_W-1:0] segs;
        segs = 7'b1111111;
        case (code)
            5'd0:       segs = 7'b1000000;
            5'd1:       segs = 7'b1111001;
            5'd2:       segs = 7'b0100100;
            5'd3:       segs = 7'b0110000;
            5'd4:       segs = 7'b0011001;
            5'd5:       segs = 7'b0010010;
            5'd6:       segs = 7'b0000010;
            5'd7:       segs = 7'b1111000;
            5'd8:       segs = 7'b0000000;
            5'd9:       segs = 7'b0010000;
            GLYPH_A:    segs = 7'b0001000;
            GLYPH_B:    segs = 7'b0000011;
            GLYPH_C:    segs = 7'b1000110;
            GLYPH_D:    segs = 7'b0100001;
            GLYPH_E:    segs = 7'b0000110;
            GLYPH_F:    segs = 7'b0001110;
            GLYPH_P:    segs = 7'b0001100;
            GLYPH_DASH: segs = 7'b0111111;
            default:    segs = 7'b1111111;
        endcase
        return segs;
    endfunction

endpackage

// File: rtl/seg_glyph_rom.sv
// Combinational glyph ROM: 5-bit display code to active-low gfedcba segments.
module seg_glyph_rom
    import seg_pkg::*;
(
    input  logic [CODE_W-1:0]  code,
    output logic [GLYPH_W-1:0] segs_c
);

    assign segs_c = glyph_lookup(code);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with a double-buffered frame store;
// new data is swapped into the active buffer only at the end of a full scan.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load,
    input  logic [CODE_W*NUM_DIGITS-1:0] codes,
    input  logic [NUM_DIGITS-1:0]      dp_in,
    input  logic [NUM_DIGITS-1:0]      blank_in,
    output logic [NUM_DIGITS-1:0]      anode,
    output logic [SEG_W-1:0]           cathode,
    output logic                       pending,
    output logic                       frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    localparam digit_t      RESET_DIGIT = '{code: GLYPH_BLANK, dp: 1'b0, blank: 1'b1};
    localparam scan_state_e RESET_STATE = (GUARD > 0) ? GUARD_S : DRIVE_S;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    scan_state_e           state_q, state_d;
    digit_t [NUM_DIGITS-1:0] act_q, act_d;
    digit_t [NUM_DIGITS-1:0] shd_q, shd_d;
    logic                  pending_q, pending_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      cathode_q, cathode_d;

    logic                  boundary_c;
    logic                  next_in_guard_c;
    digit_t [NUM_DIGITS-1:0] load_frame_c;
    digit_t                cur_c;
    logic [GLYPH_W-1:0]    glyph_c;

    // Slot counter and digit index.
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        boundary_c = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            boundary_c = (idx_q == IDX_LAST);
        end
    end

    if (GUARD > 0) begin : g_guard
        assign next_in_guard_c = (cnt_d < CNT_W'(GUARD));
    end else begin : g_no_guard
        assign next_in_guard_c = 1'b0;
    end

    // Pack the load inputs and pick the digit currently addressed.
    always_comb begin
        cur_c = act_q[0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_frame_c[i].code  = codes[i*CODE_W +: CODE_W];
            load_frame_c[i].dp    = dp_in[i];
            load_frame_c[i].blank = blank_in[i];
            if (idx_q == IDX_W'(i)) begin
                cur_c = act_q[i];
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .code   (cur_c.code),
        .segs_c (glyph_c)
    );

    // Next state, registered pin values and buffer handover.
    always_comb begin
        state_d      = next_in_guard_c ? GUARD_S : DRIVE_S;
        act_d        = act_q;
        shd_d        = shd_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        anode_d      = '1;
        cathode_d    = SEG_OFF;

        case (state_q)
            GUARD_S: ;
            DRIVE_S: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    anode_d[i] = (idx_q != IDX_W'(i));
                end
                cathode_d = cur_c.blank ? SEG_OFF : {~cur_c.dp, glyph_c};
            end
            default: ;
        endcase

        if (boundary_c) begin
            frame_done_d = 1'b1;
            pending_d    = 1'b0;
            if (load) begin
                act_d = load_frame_c;
                shd_d = load_frame_c;
            end else if (pending_q) begin
                act_d = shd_q;
            end
        end else if (load) begin
            shd_d     = load_frame_c;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            state_q      <= RESET_STATE;
            act_q        <= {NUM_DIGITS{RESET_DIGIT}};
            shd_q        <= {NUM_DIGITS{RESET_DIGIT}};
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            anode_q      <= '1;
            cathode_q    <= SEG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            act_q        <= act_d;
            shd_q        <= shd_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 8-cycle slots, 2-cycle guard)
// against a timeline model: position in the scan is derived from cycles since reset.
module tb_seg_scan_driver;

    localparam int ND   = 4;
    localparam int RDIV = 8;
    localparam int GRD  = 2;
    localparam int FRAME = ND * RDIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [19:0] codes;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        pending;
    logic        frame_done;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RDIV),
        .GUARD       (GRD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .codes      (codes),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .anode      (anode),
        .cathode    (cathode),
        .pending    (pending),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: t = cycles since reset release.
    int         t;
    logic [4:0] m_code [ND];
    logic [4:0] s_code [ND];
    logic [3:0] m_dp, m_blank, s_dp, s_blank;
    logic       m_pend;
    logic [3:0] exp_anode;
    logic [7:0] exp_cath;
    logic       exp_pend;
    logic       exp_fd;

    function automatic logic [6:0] ref_glyph(input logic [4:0] c);
        case (c)
            5'd0:  return 7'h40;
            5'd1:  return 7'h79;
            5'd2:  return 7'h24;
            5'd3:  return 7'h30;
            5'd4:  return 7'h19;
            5'd5:  return 7'h12;
            5'd6:  return 7'h02;
            5'd7:  return 7'h78;
            5'd8:  return 7'h00;
            5'd9:  return 7'h10;
            5'd10: return 7'h08;
            5'd11: return 7'h03;
            5'd12: return 7'h46;
            5'd13: return 7'h21;
            5'd14: return 7'h06;
            5'd15: return 7'h0E;
            5'd16: return 7'h0C;
            5'd17: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic tick(input logic r, input logic ld, input logic [19:0] c,
                        input logic [3:0] d, input logic [3:0] b);
        int idx;
        int cnt;
        rst_n = r; load = ld; codes = c; dp_in = d; blank_in = b;
        if (!r) begin
            exp_anode = 4'hF; exp_cath = 8'hFF; exp_pend = 1'b0; exp_fd = 1'b0;
            for (int i = 0; i < ND; i++) begin
                m_code[i] = 5'd31;
                s_code[i] = 5'd31;
            end
            m_dp = 4'h0; s_dp = 4'h0; m_blank = 4'hF; s_blank = 4'hF;
            m_pend = 1'b0;
            t = 0;
        end else begin
            idx = (t / RDIV) % ND;
            cnt = t % RDIV;
            if (cnt < GRD) begin
                exp_anode = 4'hF;
                exp_cath  = 8'hFF;
            end else begin
                exp_anode = 4'hF ^ (4'b0001 << idx);
                exp_cath  = m_blank[idx] ? 8'hFF : {~m_dp[idx], ref_glyph(m_code[idx])};
            end
            exp_fd = ((t % FRAME) == FRAME - 1);
            if (exp_fd) begin
                if (ld) begin
                    for (int i = 0; i < ND; i++) begin
                        m_code[i] = c[i*5 +: 5];
                        s_code[i] = c[i*5 +: 5];
                    end
                    m_dp = d; m_blank = b; s_dp = d; s_blank = b;
                end else if (m_pend) begin
                    for (int i = 0; i < ND; i++) m_code[i] = s_code[i];
                    m_dp = s_dp; m_blank = s_blank;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                for (int i = 0; i < ND; i++) s_code[i] = c[i*5 +: 5];
                s_dp = d; s_blank = b;
                m_pend = 1'b1;
            end
            exp_pend = m_pend;
            t++;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        int first_fd;
        first_fd = -1;
        for (int k = 0; k < 2; k++) begin
            tick(1'b0, 1'b1, 20'h12345, 4'hF, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL reset t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL idle_scan t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
            if (frame_done === 1'b1 && first_fd < 0) first_fd = k;
        end
        checks++;
        if (first_fd !== 32) begin
            failures++;
            $display("FAIL first_frame_done got cycle %0d expected 32", first_fd);
        end
    endtask

    task automatic test_digits();
        tick(1'b1, 1'b1, {5'd3, 5'd2, 5'd1, 5'd0}, 4'h0, 4'h0);
        for (int k = 0; k < 70; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL digits t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_mixed();
        tick(1'b1, 1'b1, {5'd17, 5'd16, 5'd15, 5'd10}, 4'b0001, 4'b0100);
        checks++;
        if (pending !== 1'b1) begin
            failures++;
            $display("FAIL pending_after_load got %b expected 1", pending);
        end
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL mixed t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
        tick(1'b1, 1'b1, {5'd17, 5'd16, 5'd15, 5'd25}, 4'b0000, 4'b0000);
        for (int k = 0; k < 64; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL unused_code t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 1'b1, 20'($urandom), 4'($urandom), 4'($urandom));
        tick(1'b1, 1'b1, 20'($urandom), 4'($urandom), 4'($urandom));
        for (int k = 0; k < 40 || (t % FRAME) != FRAME - 1; k++) begin
            if (k > 80) break;
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL back_to_back t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
        // Load exactly on the boundary cycle.
        tick(1'b1, 1'b1, {5'd9, 5'd8, 5'd7, 5'd6}, 4'b1010, 4'b0000);
        checks++;
        if (pending !== 1'b0 || frame_done !== 1'b1) begin
            failures++;
            $display("FAIL boundary_load pending=%b expected 0 frame_done=%b expected 1", pending, frame_done);
        end
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL boundary_frame t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < FRAME && (t % FRAME) != 2 * RDIV + 4; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
        end
        tick(1'b0, 1'b0, 20'h0, 4'h0, 4'h0);
        checks++;
        if (anode !== 4'hF || cathode !== 8'hFF || pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid anode=%b expected 1111 cathode=%h expected ff pending=%b", anode, cathode, pending);
        end
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b0, 20'h0, 4'h0, 4'h0);
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL after_reset_mid t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
    endtask

    task automatic test_random();
        logic r;
        logic ld;
        for (int k = 0; k < 800; k++) begin
            r  = ($urandom_range(299) != 0);
            ld = ($urandom_range(11) == 0);
            tick(r, ld, 20'($urandom), 4'($urandom), 4'($urandom));
            checks++;
            if ({anode, cathode, pending, frame_done} !== {exp_anode, exp_cath, exp_pend, exp_fd}) begin
                failures++;
                $display("FAIL random k=%0d t=%0d anode=%b/%b cathode=%h/%h pending=%b/%b frame_done=%b/%b",
                         k, t, anode, exp_anode, cathode, exp_cath, pending, exp_pend, frame_done, exp_fd);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; codes = '0; dp_in = '0; blank_in = '0;
        t = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_digits();
        test_mixed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
